spi_burst_ctrl: RTL
===================

# spi_burst_ctrl

Multi-byte transaction sequencer that sits directly upstream of the byte-level SPI master engine (`base_spi`). Buffers CPU write bytes in a TX FIFO, feeds them one at a time to the engine over its shared `data` bus (`we`/`en`/`oe` handshake), and collects each received byte into an RX FIFO. The CPU programs a byte count and pulses `start`; the block runs the whole burst without further CPU involvement.

## Interface
- `DEPTH`, 8: entries in each of the TX and RX FIFOs; power of two, ≥2.
- `FILL`, 8'hFF: byte transmitted when the TX FIFO is empty mid-burst.
- `TIMEOUT`, 64: cycles allowed per byte for the engine's `done`; used only with `SPI_BURST_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a burst; ignored while `busy`.
- `len` in 8: burst length in bytes, sampled on `start`; 0 means no transfer.
- `tx_wr` in 1: push `tx_data` into the TX FIFO.
- `tx_data` in 8: write byte.
- `tx_full` out 1: TX FIFO full.
- `tx_level` out $clog2(DEPTH)+1: TX occupancy.
- `rx_rd` in 1: pop the RX FIFO; `rx_data` advances next cycle.
- `rx_data` out 8: RX FIFO head, first-word fall-through.
- `rx_empty` out 1: RX FIFO empty.
- `busy` out 1: burst in progress.
- `done` out 1: one-cycle pulse at end of burst.
- `ovf` out 1: sticky flag for RX overflow or TX push-while-full; cleared by `start`.
- `tmo` out 1: sticky timeout flag; cleared by `start`; tied 0 without the macro.
- `spi_en` out 1: engine `en`.
- `spi_we` out 1: engine `we`.
- `spi_oe` out 1: engine `oe`.
- `spi_data` inout 8: engine `data`; driven only while `spi_we`=1, otherwise Z.
- `spi_done` in 1: engine `done`.
- `spi_busy` in 1: engine `busy`.

## Operation
- The FIFOs use a read pointer, a write pointer and a count. Each pointer wraps modulo `DEPTH`.
  - A push when full is dropped and sets `ovf`.
  - A pop when empty is ignored.
  - A simultaneous push and pop leaves the count unchanged.
- The FSM has states IDLE, LOAD, XFER, WAIT_END, CAPTURE, NEXT.
- **IDLE:** all `spi_*` outputs 0 and `spi_data`=Z.
  - On `start` with `len`≠0: latch `cnt`=`len`, clear `ovf`/`tmo`, set `busy`, go to LOAD.
  - On `start` with `len`=0: pulse `done` and stay in IDLE.
- **LOAD (1 cycle):** `spi_we`=1, `spi_en`=1.
  - `spi_data` = TX head, or `FILL` if the TX FIFO is empty.
  - Pop TX if it is non-empty.
  - Next state: XFER.
- **XFER:** `spi_en`=1, `spi_we`=0. Go to WAIT_END when `spi_done`=1.
- **WAIT_END:** `spi_en`=1. Go to CAPTURE when `spi_done`=0 and `spi_busy`=0, i.e. the engine is back at idle.
- **CAPTURE (1 cycle):** `spi_en`=0, `spi_oe`=1.
  - Sample `spi_data` at the end of the cycle and push it into the RX FIFO. If the RX FIFO is full, drop the byte and set `ovf`.
  - Decrement `cnt`.
  - Next state: NEXT.
- **NEXT (1 cycle, bus turnaround):** all `spi_*` outputs 0.
  - If `cnt`≠0, go to LOAD.
  - If `cnt`=0, pulse `done`, clear `busy`, go to IDLE.
- `spi_we` and `spi_oe` are never 1 in the same cycle. The CPU-side `tx_wr` and `rx_rd` are accepted in every state.

## Timing
- Reset values:
  - state IDLE; FIFOs empty.
  - `busy`, `done`, `ovf`, `tmo`, `spi_en`, `spi_we`, `spi_oe` = 0; `spi_data` = Z.
  - `tx_full` = 0, `rx_empty` = 1, `tx_level` = 0, `rx_data` = 0.
- From `start`: LOAD is the next cycle. `spi_en` rises 1 cycle after `start`.
- Per byte: 1 (LOAD) + engine time + 1 (WAIT_END exit) + 1 (CAPTURE) + 1 (NEXT).
- `done` fires 1 cycle after the last CAPTURE. The final RX byte is visible on `rx_data` in the same cycle as `done`.
- A push into an empty RX FIFO appears on `rx_data` and deasserts `rx_empty` the next cycle.
- A reset assertion mid-burst forces IDLE and flushes both FIFOs immediately, asynchronously, and releases `spi_data` to Z.

## Configuration
- `SPI_BURST_TIMEOUT_EN` defined:
  - A down-counter loads `TIMEOUT` on entering XFER and decrements in XFER and WAIT_END.
  - On reaching 0: set `tmo`, drive all `spi_*` outputs to 0, flush the TX FIFO, pulse `done`, go to IDLE. The RX FIFO is kept.
- `SPI_BURST_TIMEOUT_EN` undefined: no counter; XFER and WAIT_END wait indefinitely; `tmo` is tied to 0.

## Test plan
- **Basic 3-byte burst:** push 8'hA5, 8'h3C, 8'h0F, `len`=3, `start`, engine model loops MOSI→MISO.
  - Expect `done` exactly once, RX = A5, 3C, 0F in order, `ovf`=0, `busy` low after `done`.
- **TX underflow:** `len`=2 with a single TX byte 8'h11.
  - Expect the engine `data` samples to be 11 then FF; RX holds 2 bytes.
- **RX overflow:** `DEPTH`=8, no `rx_rd`, `len`=10.
  - Expect 8 bytes retained, `ovf`=1, `done` still pulses.
- **Zero length and busy guard:** `start` with `len`=0 gives `done` the next cycle with no `spi_en`. A second `start` during a burst is ignored: the byte count is unchanged.
- **Reset mid-burst:** drop `rst` while in XFER.
  - Expect `spi_en`=0, `spi_data`=Z, `tx_level`=0, `rx_empty`=1 immediately; a fresh 1-byte burst then succeeds.
- **Timeout (macro on):** `TIMEOUT`=16, engine model never asserts `done`.
  - Expect `tmo`=1 and a `done` pulse 16 cycles after XFER entry; TX flushed.

Source files
------------

// File: rtl/spi_burst_ctrl_if.sv
// CPU-side port bundle for spi_burst_ctrl: burst control, TX/RX FIFO access
// and status flags. The controller takes the slave modport.
interface spi_burst_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          start;
    logic [7:0]    len;
    logic          tx_wr;
    logic [7:0]    tx_data;
    logic          tx_full;
    logic [LW-1:0] tx_level;
    logic          rx_rd;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          tmo;

    modport master (
        output start, len, tx_wr, tx_data, rx_rd,
        input  tx_full, tx_level, rx_data, rx_empty, busy, done, ovf, tmo
    );

    modport slave (
        input  start, len, tx_wr, tx_data, rx_rd,
        output tx_full, tx_level, rx_data, rx_empty, busy, done, ovf, tmo
    );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Multi-byte burst sequencer in front of a byte-level SPI engine, with TX/RX FIFOs.
// Optional per-byte engine timeout is enabled by defining SPI_BURST_TIMEOUT_EN.
module spi_burst_ctrl #(
    parameter int         DEPTH   = 8,
    parameter logic [7:0] FILL    = 8'hFF,
    parameter int         TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    spi_burst_ctrl_if.slave    cpu,
    output logic               spi_en,
    output logic               spi_we,
    output logic               spi_oe,
    inout  wire  [7:0]         spi_data,
    input  logic               spi_done,
    input  logic               spi_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, XFER, WAIT_END, CAPTURE, NEXT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic          en_q, en_d, we_q, we_d, oe_q, oe_d;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [LW-1:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [LW-1:0] rx_cnt_q, rx_cnt_d;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, tx_flush, rx_cap, rx_push, rx_pop;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_q, tmo_d;
`endif

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == LW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == LW'(DEPTH));

    assign tx_push = cpu.tx_wr && !tx_full;
    assign rx_push = rx_cap && !rx_full;
    assign rx_pop  = cpu.rx_rd && !rx_empty;

    // The engine bus is only driven during LOAD; the byte is the live TX head.
    assign spi_data = we_q ? (tx_empty ? FILL : tx_mem[tx_rp_q]) : 8'hzz;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        tx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_cap   = 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
        tmr_d    = tmr_q;
        tmo_d    = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu.start) begin
                    ovf_d = 1'b0;
`ifdef SPI_BURST_TIMEOUT_EN
                    tmo_d = 1'b0;
`endif
                    if (cpu.len != 8'd0) begin
                        cnt_d   = cpu.len;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                tx_pop  = !tx_empty;
                state_d = XFER;
`ifdef SPI_BURST_TIMEOUT_EN
                tmr_d   = TW'(TIMEOUT);
`endif
            end
            XFER:     if (spi_done) state_d = WAIT_END;
            WAIT_END: if (!spi_done && !spi_busy) state_d = CAPTURE;
            CAPTURE: begin
                rx_cap  = 1'b1;
                cnt_d   = cnt_q - 8'd1;
                state_d = NEXT;
                // done/busy are registered, so they change as NEXT begins
                if (cnt_d == 8'd0) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            NEXT:     state_d = (cnt_q != 8'd0) ? LOAD : IDLE;
            default:  state_d = IDLE;
        endcase
`ifdef SPI_BURST_TIMEOUT_EN
        if (state_q == XFER || state_q == WAIT_END) begin
            tmr_d = tmr_q - TW'(1);
            if (tmr_q == TW'(1)) begin
                state_d  = IDLE;
                tmo_d    = 1'b1;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                tx_flush = 1'b1;
            end
        end
`endif
        if ((cpu.tx_wr && tx_full) || (rx_cap && rx_full)) ovf_d = 1'b1;

        en_d = (state_d == LOAD) || (state_d == XFER) || (state_d == WAIT_END);
        we_d = (state_d == LOAD);
        oe_d = (state_d == CAPTURE);
    end

    always_comb begin
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        tx_cnt_d = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
        if (tx_flush) begin
            tx_wp_d  = tx_wp_q;
            tx_rp_d  = tx_wp_q;
            tx_cnt_d = '0;
        end
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        rx_cnt_d = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
`ifdef SPI_BURST_TIMEOUT_EN
            tmr_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            en_q     <= en_d;
            we_q     <= we_d;
            oe_q     <= oe_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
`ifdef SPI_BURST_TIMEOUT_EN
            tmr_q    <= tmr_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers and counts.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= cpu.tx_data;
        if (rx_push) rx_mem[rx_wp_q] <= spi_data;
    end

    assign spi_en       = en_q;
    assign spi_we       = we_q;
    assign spi_oe       = oe_q;
    assign cpu.tx_full  = tx_full;
    assign cpu.tx_level = tx_cnt_q;
    assign cpu.rx_data  = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
    assign cpu.rx_empty = rx_empty;
    assign cpu.busy     = busy_q;
    assign cpu.done     = done_q;
    assign cpu.ovf      = ovf_q;
`ifdef SPI_BURST_TIMEOUT_EN
    assign cpu.tmo      = tmo_q;
`else
    assign cpu.tmo      = 1'b0;
`endif
endmodule
